// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Arbitrates two writeback requesters onto one register-file write port.
// The two requesters are A (ALU) and B (load or multi-cycle unit).
// When both request in the same cycle, round-robin picks the one that was
// not granted most recently. The accepted write is registered with one
// cycle of latency.
// An optional scoreboard is enabled by defining RF_WB_SCOREBOARD_EN. It keeps
// a 32-entry busy vector: issue sets an entry and the register-file commit
// clears it. It also reports whether the two source registers are busy.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   a_valid/a_addr/a_data/a_ready  requester A handshake
//   b_valid/b_addr/b_data/b_ready  requester B handshake
//   iss_valid, iss_rd              issuing instruction and its destination
//   rs1_addr, rs2_addr             source registers to look up
//   rs1_busy, rs2_busy             source register has a pending write
//   rf_wr_en/rf_wr_addr/rf_wr_data register-file write port
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [4:0]            a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [4:0]            b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wr_en,
  output logic [4:0]            rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data
);

  // 1: B was granted most recently, so A wins the next contention.
  logic last_b;

  logic [4:0] sel_addr;

  // Both readies are gated by rst_n, so no handshake can complete while
  // the block is in reset.
  always_comb begin
    a_ready = rst_n & a_valid & (~b_valid | last_b);
    b_ready = rst_n & b_valid & (~a_valid | ~last_b);
  end

  assign sel_addr = b_ready ? b_addr : a_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b     <= 1'b1;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else if (a_ready || b_ready) begin
      last_b     <= b_ready;
      rf_wr_addr <= sel_addr;
      rf_wr_data <= b_ready ? b_data : a_data;
      // A write to x0 still completes the handshake but never commits.
      rf_wr_en   <= (sel_addr != 5'd0);
    end else begin
      rf_wr_en   <= 1'b0;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  // The clear is applied first, so a set to the same register on the same
  // edge wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_wr_en) busy_nxt[rf_wr_addr] = 1'b0;
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
`else
  // Without the scoreboard, the issue and source-lookup inputs are not used.
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{iss_valid, iss_rd, rs1_addr, rs2_addr};
  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the write-data width.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 The ports SHALL be, in order:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- a_valid  in  1  requester A (ALU writeback) has a write
- a_addr  in  5  requester A destination register
- a_data  in  DATA_WIDTH  requester A write data
- a_ready  out  1  requester A write accepted this cycle
- b_valid, b_addr, b_data, b_ready  same as A; requester B (load/multi-cycle unit)
- iss_valid  in  1  an instruction writing iss_rd issues this cycle
- iss_rd  in  5  destination of the issuing instruction
- rs1_addr, rs2_addr  in  5  source registers to check
- rs1_busy, rs2_busy  out  1  source register has a pending write
- rf_wr_en  out  1  register-file write enable
- rf_wr_addr  out  5  register-file write address
- rf_wr_data  out  DATA_WIDTH  register-file write data

Function
REQ-004 A transfer on port X SHALL occur in any cycle with X_valid && X_ready.
REQ-005 a_ready and b_ready SHALL be combinational from the valids and the round-robin pointer, and never both 1.
REQ-006 With exactly one valid requester, that requester SHALL get ready=1.
REQ-007 With both valid, the requester not granted most recently SHALL get ready=1.
REQ-008 The round-robin pointer SHALL update only on a transfer and SHALL record the granted requester.
REQ-009 A requester SHALL hold valid, addr and data stable until ready; a valid dropped before ready SHALL have no effect.
REQ-010 A transfer SHALL register addr and data into rf_wr_addr and rf_wr_data on the same edge (latency 1).
REQ-011 rf_wr_en SHALL be 1 in the following cycle only if the transfer address is non-zero.
REQ-012 A transfer to x0 SHALL complete the handshake with rf_wr_en=0.
REQ-013 With no transfer, rf_wr_en SHALL be 0 next cycle; rf_wr_addr and rf_wr_data SHALL hold their values.
REQ-014 Back-to-back transfers SHALL be supported, one per cycle, with no bubble.
REQ-015 The scoreboard SHALL be a 32-bit busy vector; bit 0 SHALL always read 0.
REQ-016 iss_valid with iss_rd != 0 SHALL set busy[iss_rd] at the next edge.
REQ-017 rf_wr_en=1 SHALL clear busy[rf_wr_addr] at that edge, the same edge the register file commits.
REQ-018 If a set and a clear target the same register on one edge, the set SHALL win.
REQ-019 Issuing to an already-busy register SHALL leave it busy; no count is kept, and the issuer SHALL not issue WAW on a busy register.
REQ-020 rsN_busy SHALL equal busy[rsN_addr], combinational, and SHALL be 0 for address 0.

Reset
REQ-021 With rst_n=0 at an edge, the block SHALL clear busy to 0, rf_wr_en, rf_wr_addr and rf_wr_data to 0, and set the pointer to B, so A wins the first contention.
REQ-022 During reset, a_ready and b_ready SHALL be 0.
REQ-023 A transfer pending or registered when reset asserts SHALL be dropped, and rf_wr_en SHALL be 0 in the cycle after reset.

Configuration
REQ-024 With macro RF_WB_SCOREBOARD_EN defined, the busy vector and REQ-015..REQ-020 SHALL be implemented.
REQ-025 Without RF_WB_SCOREBOARD_EN, no busy storage SHALL exist, rs1_busy and rs2_busy SHALL be constant 0, iss_valid and iss_rd SHALL be ignored, and arbitration SHALL be unchanged.

Verification
REQ-026 Reset then a_valid, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 that cycle; next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF.
REQ-027 Both valid for 4 cycles (A addr 1, B addr 2) -> grants A,B,A,B; rf_wr_addr sequence 1,2,1,2, one cycle later.
REQ-028 b_valid, b_addr=0, b_data=0x1234 -> b_ready=1; next cycle rf_wr_en=0.
REQ-029 With the scoreboard macro defined, iss_rd=7 and rs1_addr=7 -> rs1_busy=1 next cycle. A write to 7 then clears it: rs1_busy=1 through the rf_wr_en cycle and 0 the cycle after. A same-edge re-issue to 7 keeps it 1.
REQ-030 Reset asserted in the cycle after an A transfer -> rf_wr_en=0 after reset, busy all 0, and the next contention grants A.
